// File: rtl/dma_read_responder_if.sv
// Layer weight-fetch handshake plus memory read port of the DMA read responder.
// The responder connects through the slave modport; the layer/memory side uses master.
interface dma_read_responder_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 512
);
  logic                  dma_engineer_req;
  logic                  dma_engineer_ack;
  logic [ADDR_WIDTH-1:0] dma_engineer_start_addr;
  logic [ADDR_WIDTH-1:0] dma_engineer_length;
  logic [DATA_WIDTH-1:0] dma_engineer_dout;
  logic                  dma_engineer_dout_en;
  logic                  dma_engineer_dout_eop;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic                  mem_rd_rdy;
  logic                  mem_rd_dout_en;
  logic [DATA_WIDTH-1:0] mem_rd_dout;
  logic                  dma_busy;

  modport slave (
    input  dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
           mem_rd_rdy, mem_rd_dout_en, mem_rd_dout,
    output dma_engineer_ack, dma_engineer_dout, dma_engineer_dout_en,
           dma_engineer_dout_eop, mem_rd_en, mem_rd_addr, dma_busy
  );

  modport master (
    output dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
           mem_rd_rdy, mem_rd_dout_en, mem_rd_dout,
    input  dma_engineer_ack, dma_engineer_dout, dma_engineer_dout_en,
           dma_engineer_dout_eop, mem_rd_en, mem_rd_addr, dma_busy
  );
endinterface

// File: rtl/dma_read_responder.sv
// Accepts a layer weight-fetch request, issues word reads to memory with a bounded
// number in flight, and streams the in-order responses back with an end-of-packet flag.
module dma_read_responder #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 16,
  parameter int CNT_WIDTH       = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  dma_read_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  C_LIMIT = CNT_WIDTH'(MAX_OUTSTANDING);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] issued_q, issued_d;
  logic [ADDR_WIDTH-1:0] received_q, received_d;
  logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ack_q, ack_d;
  logic                  dout_en_q, dout_en_d;
  logic                  eop_q, eop_d;
  logic                  busy_q, busy_d;

  logic rd_en, issue_fire, capture, last_capture;

  assign rd_en        = (state_q == ISSUE) && (issued_q < len_q) && (outstanding_q < C_LIMIT);
  assign issue_fire   = rd_en && bus.mem_rd_rdy;
  assign capture      = (state_q != IDLE) && bus.mem_rd_dout_en;
  assign last_capture = capture && (received_q == (len_q - A_ONE));

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    len_d         = len_q;
    issued_d      = issued_q;
    received_d    = received_q;
    outstanding_d = outstanding_q;
    dout_d        = dout_q;
    ack_d         = 1'b0;
    dout_en_d     = capture;
    eop_d         = last_capture;

    if (capture) begin
      dout_d     = bus.mem_rd_dout;
      received_d = received_q + A_ONE;
    end

    if (issue_fire && !capture) begin
      outstanding_d = outstanding_q + C_ONE;
    end else if (!issue_fire && capture && (outstanding_q != '0)) begin
      outstanding_d = outstanding_q - C_ONE;
    end

    unique case (state_q)
      IDLE: begin
        // ack_q blocks a req still held during the ack cycle of a zero-length fetch
        if (bus.dma_engineer_req && !ack_q) begin
          addr_d        = bus.dma_engineer_start_addr;
          len_d         = bus.dma_engineer_length;
          issued_d      = '0;
          received_d    = '0;
          outstanding_d = '0;
          ack_d         = 1'b1;
          if (bus.dma_engineer_length != '0) state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (issue_fire) begin
          issued_d = issued_q + A_ONE;
          addr_d   = addr_q + A_ONE;
          if ((issued_q + A_ONE) == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_capture) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      issued_q      <= '0;
      received_q    <= '0;
      outstanding_q <= '0;
      dout_q        <= '0;
      ack_q         <= 1'b0;
      dout_en_q     <= 1'b0;
      eop_q         <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      issued_q      <= issued_d;
      received_q    <= received_d;
      outstanding_q <= outstanding_d;
      dout_q        <= dout_d;
      ack_q         <= ack_d;
      dout_en_q     <= dout_en_d;
      eop_q         <= eop_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.dma_engineer_ack      = ack_q;
  assign bus.dma_engineer_dout     = dout_q;
  assign bus.dma_engineer_dout_en  = dout_en_q;
  assign bus.dma_engineer_dout_eop = eop_q;
  assign bus.mem_rd_en             = rd_en;
  assign bus.mem_rd_addr           = addr_q;
  assign bus.dma_busy              = busy_q;
endmodule

// File: doc/dma_read_responder.md
Name: dma_read_responder

Overview:
- Responder end of the layer-to-DMA weight-fetch handshake.
- Layer controllers raise dma_engineer_req with a start address and length. This block acknowledges the request, then issues word-granular reads to the external memory port.
- Returned 512-bit words are streamed back to the layer on dma_engineer_dout/_en, with _eop on the final word.
- Sits between the layer's double-buffered weight RAM writer and the memory read port.

Parameters:
- ADDR_WIDTH, 27, width of start address, length and memory address (units of 512-bit words).
- DATA_WIDTH, 512, width of memory read data and dma_engineer_dout.
- MAX_OUTSTANDING, 16, maximum memory reads issued but not yet returned.
- CNT_WIDTH, 5, width of the outstanding counter; must hold MAX_OUTSTANDING.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- dma_engineer_req  input  1  level request from the layer; held until ack is seen.
- dma_engineer_ack  output  1  one-cycle acknowledge pulse.
- dma_engineer_start_addr  input  ADDR_WIDTH  first word address; valid while req is high.
- dma_engineer_length  input  ADDR_WIDTH  number of words to fetch; valid while req is high.
- dma_engineer_dout  output  DATA_WIDTH  returned data word.
- dma_engineer_dout_en  output  1  dout valid strobe.
- dma_engineer_dout_eop  output  1  last word of the transfer; coincident with dout_en.
- mem_rd_en  output  1  memory read request.
- mem_rd_addr  output  ADDR_WIDTH  memory read word address.
- mem_rd_rdy  input  1  memory accepts the request this cycle (transfer = en & rdy).
- mem_rd_dout_en  input  1  memory read data valid; responses return in order.
- mem_rd_dout  input  DATA_WIDTH  memory read data.
- dma_busy  output  1  high in any state other than IDLE.

Behaviour:
- All outputs are registered except mem_rd_en, which is decoded from registered state only. There is no combinational input-to-output path.
- Reset values:
  - ack=0, dout=0, dout_en=0, dout_eop=0, mem_rd_addr=0, dma_busy=0.
  - mem_rd_en=0; state=IDLE.
  - Issue, receive and outstanding counters = 0.
- States: IDLE, ISSUE, DRAIN.
- IDLE, req=1 sampled:
  - Latch start_addr into mem_rd_addr and length into len_r.
  - Drive ack=1 in the following cycle, for exactly one cycle.
  - Next state: ISSUE if length!=0; otherwise stay IDLE. A zero-length request is acked; no data and no eop follow.
- Req handling outside IDLE: ignored; no second ack. A req still high in the cycle after ack returns to IDLE is treated as a new request.
- ISSUE:
  - mem_rd_en = (issued < len_r) && (outstanding < MAX_OUTSTANDING).
  - On en&rdy: issued += 1; mem_rd_addr += 1 (wraps modulo 2^ADDR_WIDTH).
  - mem_rd_en and mem_rd_addr hold stable while rdy=0.
  - Go to DRAIN when the final issue is accepted.
- Outstanding counter:
  - +1 on an accepted issue; -1 on mem_rd_dout_en.
  - Both in the same cycle leave it unchanged.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Return path, any non-IDLE state:
  - mem_rd_dout_en=1 → next cycle dout=mem_rd_dout and dout_en=1. Latency is exactly 1 cycle.
  - dout_eop=1 when received == len_r-1 at capture; received += 1.
- DRAIN: issues nothing. When the last word is captured (eop cycle), go to IDLE in the same edge. dma_busy falls with eop.
- Data is dropped silently in IDLE: mem_rd_dout_en in IDLE produces no dout_en.
- Downstream has no backpressure; one word per cycle must be sustained.
- Back-to-back transfers: a req present in the cycle after eop is accepted; the minimum gap from eop to the next ack is 1 cycle.
- Reset mid-transfer: all counters clear, state returns to IDLE, and any in-flight responses arriving after reset are dropped.

Test Plan:
- Single transfer: start_addr=900, length=100, rdy=1, memory latency 4 → ack 1 cycle after req. mem_rd_addr runs 900..999. 100 dout_en pulses in order, eop only on the 100th. dma_busy low after eop.
- Backpressure: length=8, rdy toggles 1,0,0,1,… → addresses 0..7 each issued exactly once and held during rdy=0. 8 words out; eop on word 8.
- Outstanding limit: MAX_OUTSTANDING=16, length=40, memory latency 30 → mem_rd_en drops after 16 issues. Outstanding never exceeds 16. All 40 words delivered in order.
- Zero length and stray data: length=0 → one ack, no dout_en, no eop, busy stays 0. mem_rd_dout_en pulse while IDLE → no dout_en.
- Wrap and back-to-back: start_addr=2^27-2, length=4 → addresses 2^27-2, 2^27-1, 0, 1. Second req held through eop is acked 1 cycle later.
- Reset mid-transfer: rst asserted after 10 of 50 words returned → all outputs 0 next cycle, state IDLE. Late memory responses ignored; a new request completes normally.
